debounce_fsm: RTL
=================

# debounce_fsm

- Control stage of the debouncing circuit. Sits between the raw push-button/switch input and the delay timer.
- Synchronises the noisy input and drives the timer's enable (`timer_EN`).
- Consumes the timer's completion flag (`timer_DONE`) and produces a clean debounced level, single-cycle rise/fall pulses and a saturating glitch count.

## Interface

Parameters:
- `SYNC_STAGES`, 2: number of flip-flops in the input synchroniser (legal range 2..4).
- `GLITCH_CNT_WIDTH`, 8: width of the glitch counter.

Ports:
- `CLK`, in, 1: single clock. All state changes on the rising edge.
- `RST`, in, 1: reset, synchronous, active-high.
- `noisy_in`, in, 1: raw asynchronous input from the pad.
- `timer_DONE`, in, 1: completion flag from the delay timer. Stays high while the timer is enabled and expired.
- `timer_EN`, out, 1: timer enable. While low, the timer clears its count and its DONE flag.
- `debounced_out`, out, 1: stable, debounced level.
- `rise_pulse`, out, 1: one-cycle pulse when `debounced_out` goes 0→1.
- `fall_pulse`, out, 1: one-cycle pulse when `debounced_out` goes 1→0.
- `glitch_count`, out, GLITCH_CNT_WIDTH: number of aborted stability checks. Saturates at all-ones.

## Operation

- `s` is the output of the last synchroniser flop. `noisy_in` is used nowhere else.
- States: `STABLE_LOW` (reset state), `CHECK_HIGH`, `STABLE_HIGH`, `CHECK_LOW`. Encoding is free.
- `timer_EN` = 1 exactly when the state is `CHECK_HIGH` or `CHECK_LOW`.
  - It is decoded from the state register only, with no combinational path from `s` or `timer_DONE`.
- `first` is a one-bit flag. It is set on every entry into a CHECK state and cleared after that state's first cycle. While `first` = 1, `timer_DONE` is ignored, which rejects a stale DONE.
- Transitions, evaluated each cycle:
  - `STABLE_LOW`: `s`=1 → `CHECK_HIGH`. Otherwise stay.
  - `CHECK_HIGH`:
    - `s`=0 → `STABLE_LOW`; `glitch_count` +1 (saturating).
    - Else, if `timer_DONE`=1 and `first`=0 → `STABLE_HIGH`; `debounced_out`←1; `rise_pulse`←1 for one cycle.
    - Otherwise stay.
  - `STABLE_HIGH`: `s`=0 → `CHECK_LOW`. Otherwise stay.
  - `CHECK_LOW`: mirror of `CHECK_HIGH`.
    - `s`=1 → `STABLE_HIGH`; glitch +1.
    - `timer_DONE` (with `first`=0) → `STABLE_LOW`; `debounced_out`←0; `fall_pulse`←1.
- Simultaneous events: in a CHECK state, if `s` reverts in the same cycle that `timer_DONE`=1, the reversion wins. The result is a glitch, and `debounced_out` is unchanged.
- `timer_DONE` is ignored in both STABLE states.
- Every path from a CHECK state back to a STABLE state spends at least one cycle with `timer_EN`=0. This guarantees the timer restarts from zero on the next check.
- `glitch_count` saturates: at all-ones, further glitches leave it unchanged. It clears only on reset.

## Timing

- Reset values (after a clock edge with `RST`=1):
  - state = `STABLE_LOW`
  - all synchroniser flops = 0
  - `first` = 0
  - `timer_EN` = 0
  - `debounced_out` = 0
  - `rise_pulse` = 0
  - `fall_pulse` = 0
  - `glitch_count` = 0
- Reset asserted mid-check takes effect at the next edge. `timer_EN` drops in the following cycle.
- `debounced_out`, `rise_pulse`, `fall_pulse` and `glitch_count` are registered outputs.
- Latency:
  - A `noisy_in` edge reaches `s` after `SYNC_STAGES` edges.
  - The state enters the CHECK state at the next edge, and `timer_EN` rises then.
  - If `timer_DONE` is first sampled high in cycle k (with `first`=0), `debounced_out` and the pulse change at edge k+1.
  - The pulse drops at edge k+2.
- `rise_pulse` and `fall_pulse` are never high in the same cycle. Each is high for exactly one cycle per transition.

## Test plan

Bench timer model: asserts `timer_DONE` 4 cycles after `timer_EN` rises, and clears DONE the cycle after EN falls. `SYNC_STAGES` = 2.

1. Reset check: hold `RST`=1 for 3 cycles with `noisy_in`=1 → all outputs 0 and `timer_EN`=0 during and immediately after reset.
2. Clean press: `noisy_in` 0→1 and held →
   - `timer_EN` rises 3 edges later.
   - `debounced_out` = 1 and `rise_pulse` = 1 for exactly one cycle, 1 edge after DONE is sampled.
   - `glitch_count` = 0.
3. Bounce: toggle `noisy_in` every 2 cycles ×5, then hold 1 →
   - `glitch_count` = 5.
   - `timer_EN` drops for at least 1 cycle after each bounce.
   - A single `rise_pulse` occurs after the final hold.
4. Release race: in `CHECK_LOW`, drive `s` back to 1 in the same cycle as `timer_DONE` → state returns to `STABLE_HIGH`, `debounced_out` stays 1, no `fall_pulse`, `glitch_count` +1.
5. Saturation: with `GLITCH_CNT_WIDTH`=2, generate 6 glitches → `glitch_count` = 3 and holds at 3.
6. Reset mid-check: assert `RST` during `CHECK_HIGH` → next cycle state = `STABLE_LOW`, `timer_EN`=0, `debounced_out`=0, no pulse.

Source files
------------

// File: rtl/debounce_fsm.sv
// Debounce control stage: synchronises a noisy input and sequences an external delay timer.
// It produces a clean debounced level, one-cycle edge pulses and a saturating glitch count.
module debounce_fsm #(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned GLITCH_CNT_WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        noisy_in,
  input  logic                        timer_DONE,
  output logic                        timer_EN,
  output logic                        debounced_out,
  output logic                        rise_pulse,
  output logic                        fall_pulse,
  output logic [GLITCH_CNT_WIDTH-1:0] glitch_count
);

  typedef enum logic [1:0] {
    StStableLow,
    StCheckHigh,
    StStableHigh,
    StCheckLow
  } state_e;

  state_e                      state_q;
  logic [SYNC_STAGES-1:0]      sync_q;
  logic                        first_q;
  logic                        level_q;
  logic                        rise_q;
  logic                        fall_q;
  logic [GLITCH_CNT_WIDTH-1:0] glitch_q;
  logic                        s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StStableLow;
      sync_q   <= '0;
      first_q  <= 1'b0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], noisy_in};
      first_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      unique case (state_q)
        StStableLow: begin
          if (s) begin
            state_q <= StCheckHigh;
            first_q <= 1'b1;
          end
        end
        StCheckHigh: begin
          // A reversion beats a simultaneous DONE; DONE in the first cycle may be stale.
          if (!s) begin
            state_q <= StStableLow;
            if (glitch_q != '1) glitch_q <= glitch_q + GLITCH_CNT_WIDTH'(1);
          end else if (timer_DONE && !first_q) begin
            state_q <= StStableHigh;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end
        end
        StStableHigh: begin
          if (!s) begin
            state_q <= StCheckLow;
            first_q <= 1'b1;
          end
        end
        StCheckLow: begin
          if (s) begin
            state_q <= StStableHigh;
            if (glitch_q != '1) glitch_q <= glitch_q + GLITCH_CNT_WIDTH'(1);
          end else if (timer_DONE && !first_q) begin
            state_q <= StStableLow;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end
        end
        default: state_q <= StStableLow;
      endcase
    end
  end

  assign timer_EN      = (state_q == StCheckHigh) || (state_q == StCheckLow);
  assign debounced_out = level_q;
  assign rise_pulse    = rise_q;
  assign fall_pulse    = fall_q;
  assign glitch_count  = glitch_q;

endmodule
